// File: rtl/round_sequencer_if.sv
// Purpose: bundles the game-control signals between round_sequencer and its
// surroundings (go button, input listeners, lives/score counters, prompt outputs).
// master: drives start/input_event/input_code/lives_zero and observes the game outputs.
// slave : the sequencer itself.
interface round_sequencer_if;
  logic       start;
  logic       input_event;
  logic [1:0] input_code;
  logic       lives_zero;
  logic [2:0] prompt;
  logic       awaiting_input;
  logic [4:0] level;
  logic [3:0] step_idx;
  logic       new_game;
  logic       score_up;
  logic       life_down;
  logic       game_over;
  logic       game_won;

  modport master (
    output start, input_event, input_code, lives_zero,
    input  prompt, awaiting_input, level, step_idx,
           new_game, score_up, life_down, game_over, game_won
  );

  modport slave (
    input  start, input_event, input_code, lives_zero,
    output prompt, awaiting_input, level, step_idx,
           new_game, score_up, life_down, game_over, game_won
  );
endinterface

// File: rtl/round_sequencer.sv
// Purpose: runs one prompt-memory game. Each level appends a random 2-bit step,
// plays the whole sequence out as timed prompt codes, then checks the player's
// input events against it with a per-step timeout.
// Ports:
//   clock, reset     - system clock, synchronous active-low reset
//   sif (slave)      - start, input_event, input_code, lives_zero in;
//                      prompt, awaiting_input, level, step_idx, new_game,
//                      score_up, life_down, game_over, game_won out (all registered)
module round_sequencer #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned SHOW_TICKS    = 25000000,
  parameter int unsigned GAP_TICKS     = 12500000,
  parameter int unsigned TIMEOUT_TICKS = 150000000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic              clock,
  input logic              reset,
  round_sequencer_if.slave sif
);

  localparam int unsigned TIMER_W = 28;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned DEPTH   = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_APPEND, S_SHOW_ON, S_SHOW_OFF, S_INPUT,
    S_PASS, S_FAIL, S_FAIL_WAIT, S_OVER
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 start_q;
  logic                 game_won_q, game_won_d;
  logic                 new_game_q, new_game_d;
  logic                 score_up_q, score_up_d;
  logic                 life_down_q, life_down_d;
  logic                 game_over_q, game_over_d;
  logic                 awaiting_q, awaiting_d;
  logic [2:0]           prompt_q, prompt_d;
  logic [1:0]           mem_q [DEPTH];

  logic                 start_rise;
  logic                 last_step;
  logic                 mem_we;
  logic [1:0]           show_code;

  assign start_rise = sif.start & ~start_q;
  assign last_step  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    game_won_d = game_won_q;
    new_game_d = 1'b0;
    mem_we     = 1'b0;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          new_game_d = 1'b1;
          len_d      = '0;
          state_d    = S_APPEND;
        end
      end
      S_APPEND: begin
        mem_we  = 1'b1;
        len_d   = len_q + LEN_W'(1);
        idx_d   = '0;
        timer_d = '0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer_q == TIMER_W'(SHOW_TICKS - 1)) begin
          timer_d = '0;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_SHOW_OFF: begin
        if (timer_q == TIMER_W'(GAP_TICKS - 1)) begin
          timer_d = '0;
          if (last_step) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_INPUT: begin
        timer_d = timer_q + TIMER_W'(1);
        // An event wins over a timeout expiring in the same cycle
        if (sif.input_event) begin
          if (sif.input_code == mem_q[idx_q]) begin
            if (last_step) begin
              state_d = S_PASS;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              timer_d = '0;
            end
          end else begin
            state_d = S_FAIL;
          end
        end else if (timer_q == TIMER_W'(TIMEOUT_TICKS - 1)) begin
          state_d = S_FAIL;
        end
      end
      S_PASS: begin
        if (len_q == LEN_W'(MAX_LEN)) begin
          game_won_d = 1'b1;
          state_d    = S_OVER;
        end else begin
          state_d = S_APPEND;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL_WAIT;
      end
      S_FAIL_WAIT: begin
        // Lives counter has had one edge to absorb life_down
        if (sif.lives_zero) begin
          game_won_d = 1'b0;
          state_d    = S_OVER;
        end else begin
          idx_d   = '0;
          timer_d = '0;
          state_d = S_SHOW_ON;
        end
      end
      S_OVER: begin
        if (start_rise) begin
          game_won_d = 1'b0;
          new_game_d = 1'b1;
          len_d      = '0;
          state_d    = S_APPEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The step being appended is not in memory yet when SHOW_ON is entered
    if ((state_q == S_APPEND) && (idx_d == len_q[IDX_W-1:0])) begin
      show_code = lfsr_q[1:0];
    end else begin
      show_code = mem_q[idx_d];
    end

    prompt_d    = (state_d == S_SHOW_ON) ? ({1'b0, show_code} + 3'd1) : 3'd0;
    awaiting_d  = (state_d == S_INPUT);
    score_up_d  = (state_d == S_PASS);
    life_down_d = (state_d == S_FAIL);
    game_over_d = (state_d == S_OVER);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      start_q     <= 1'b0;
      game_won_q  <= 1'b0;
      new_game_q  <= 1'b0;
      score_up_q  <= 1'b0;
      life_down_q <= 1'b0;
      game_over_q <= 1'b0;
      awaiting_q  <= 1'b0;
      prompt_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      start_q     <= sif.start;
      game_won_q  <= game_won_d;
      new_game_q  <= new_game_d;
      score_up_q  <= score_up_d;
      life_down_q <= life_down_d;
      game_over_q <= game_over_d;
      awaiting_q  <= awaiting_d;
      prompt_q    <= prompt_d;
    end
  end

  // Sequence memory; contents need no reset
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem_q[len_q[IDX_W-1:0]] <= lfsr_q[1:0];
    end
  end

  assign sif.prompt         = prompt_q;
  assign sif.awaiting_input = awaiting_q;
  assign sif.level          = len_q;
  assign sif.step_idx       = idx_q;
  assign sif.new_game       = new_game_q;
  assign sif.score_up       = score_up_q;
  assign sif.life_down      = life_down_q;
  assign sif.game_over      = game_over_q;
  assign sif.game_won       = game_won_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Purpose: self-checking bench for round_sequencer. A game-level model keeps the
// expected prompt sequence in a queue: each level's playback must repeat the
// known prefix and contributes one new step, which is then fed back as input.
module tb_round_sequencer;
  localparam int unsigned SHOW = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned TO   = 20;
  localparam int unsigned MAXL = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  round_sequencer_if sif ();

  round_sequencer #(
    .MAX_LEN      (MAXL),
    .SHOW_TICKS   (SHOW),
    .GAP_TICKS    (GAP),
    .TIMEOUT_TICKS(TO),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sif  (sif)
  );

  int checks = 0;
  int failures = 0;
  int seq[$];
  int shown[$];
  int score_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [18:0] outs();
    return {sif.prompt, sif.awaiting_input, sif.level, sif.step_idx, sif.new_game,
            sif.score_up, sif.life_down, sif.game_over, sif.game_won};
  endfunction

  // Advance (bounded) to the first cycle a prompt is visible
  task automatic wait_show(input int exp_level);
    int n = 0;
    while (sif.prompt == 3'd0 && n < 12) begin
      tick();
      n++;
    end
    check("show_start", 32'(sif.prompt != 3'd0), 32'd1);
    check("show_level", 32'(sif.level), 32'(exp_level));
  endtask

  // Record n prompts, checking each is held SHOW cycles followed by GAP blank cycles
  task automatic watch_playback(input int n);
    shown.delete();
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < int'(SHOW); c++) begin
        if (c == 0) begin
          check("prompt_range", 32'(sif.prompt >= 3'd1 && sif.prompt <= 3'd4), 32'd1);
          shown.push_back(int'(sif.prompt) - 1);
        end else begin
          check("prompt_hold", 32'(sif.prompt), 32'(shown[p] + 1));
        end
        check("show_idx", 32'(sif.step_idx), 32'(p));
        tick();
      end
      for (int c = 0; c < int'(GAP); c++) begin
        check("prompt_gap", 32'(sif.prompt), 32'd0);
        tick();
      end
    end
    check("awaiting_after_show", 32'(sif.awaiting_input), 32'd1);
    check("input_idx0", 32'(sif.step_idx), 32'd0);
  endtask

  // Known prefix must replay unchanged; the last shown step is new
  task automatic learn(input int lvl);
    for (int i = 0; i < lvl - 1; i++) check("replay_prefix", 32'(shown[i]), 32'(seq[i]));
    seq.push_back(shown[lvl-1]);
  endtask

  // Feed the expected sequence back; first_wait < 0 picks a random idle gap
  task automatic answer(input int first_wait);
    int w;
    for (int i = 0; i < seq.size(); i++) begin
      w = (i == 0 && first_wait >= 0) ? first_wait : int'($urandom_range(0, 3));
      repeat (w) tick();
      check("answer_idx", 32'(sif.step_idx), 32'(i));
      sif.input_event = 1'b1;
      sif.input_code  = 2'(seq[i]);
      tick();
      sif.input_event = 1'b0;
      if (i < seq.size() - 1) begin
        check("answer_advance", 32'(sif.step_idx), 32'(i + 1));
        check("answer_awaiting", 32'(sif.awaiting_input), 32'd1);
      end else begin
        check("pass_score_up", 32'(sif.score_up), 32'd1);
        check("pass_no_life_down", 32'(sif.life_down), 32'd0);
        if (sif.score_up) score_pulses++;
      end
    end
  endtask

  initial begin
    int n;
    int wrong;
    sif.start       = 1'b0;
    sif.input_event = 1'b0;
    sif.input_code  = 2'd0;
    sif.lives_zero  = 1'b0;
    reset           = 1'b0;

    // Reset state
    repeat (2) tick();
    check("reset_outs", 32'(outs()), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_outs", 32'(outs()), 32'd0);

    // Step 1: start, single new_game pulse, first prompt; start stays high through playback
    sif.start = 1'b1;
    tick();
    check("new_game_pulse", 32'(sif.new_game), 32'd1);
    check("append_level", 32'(sif.level), 32'd0);
    tick();
    check("new_game_single", 32'(sif.new_game), 32'd0);
    wait_show(1);
    watch_playback(1);
    learn(1);
    check("held_start_no_restart", 32'(sif.level), 32'd1);
    sif.start = 1'b0;

    // Step 2: answer level 1, level 2 playback repeats first prompt
    answer(-1);
    tick();
    check("score_up_single", 32'(sif.score_up), 32'd0);
    wait_show(2);
    watch_playback(2);
    learn(2);

    // Step 3: wrong code on step 0 with lives remaining; same sequence replays
    wrong = (seq[0] + 1 + int'($urandom_range(0, 2))) % 4;
    sif.input_event = 1'b1;
    sif.input_code  = 2'(wrong);
    tick();
    sif.input_event = 1'b0;
    check("wrong_life_down", 32'(sif.life_down), 32'd1);
    check("wrong_level", 32'(sif.level), 32'd2);
    tick();
    check("life_down_single", 32'(sif.life_down), 32'd0);
    wait_show(2);
    watch_playback(2);
    for (int i = 0; i < 2; i++) check("replay_after_fail", 32'(shown[i]), 32'(seq[i]));

    // Step 4: timeout after exactly TO cycles, then game over with no lives
    n = 0;
    while (!sif.life_down && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO));
    sif.lives_zero = 1'b1;
    n = 0;
    while (!sif.game_over && n < 5) begin
      tick();
      n++;
    end
    check("lost_game_over", 32'(sif.game_over), 32'd1);
    check("lost_game_won", 32'(sif.game_won), 32'd0);
    check("lost_prompt", 32'(sif.prompt), 32'd0);
    sif.input_event = 1'b1;
    sif.input_code  = 2'(int'($urandom_range(0, 3)));
    tick();
    sif.input_event = 1'b0;
    check("over_ignores_input", 32'(sif.game_over), 32'd1);
    sif.lives_zero = 1'b0;

    // Step 5: new game, win all levels; level 1 answered on the last timeout cycle
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    check("restart_new_game", 32'(sif.new_game), 32'd1);
    seq.delete();
    score_pulses = 0;
    for (int lvl = 1; lvl <= int'(MAXL); lvl++) begin
      wait_show(lvl);
      watch_playback(lvl);
      learn(lvl);
      answer(lvl == 1 ? int'(TO) - 1 : -1);
    end
    tick();
    check("win_score_pulses", 32'(score_pulses), 32'(MAXL));
    check("win_game_over", 32'(sif.game_over), 32'd1);
    check("win_game_won", 32'(sif.game_won), 32'd1);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    check("rewin_new_game", 32'(sif.new_game), 32'd1);
    check("rewin_game_won_clear", 32'(sif.game_won), 32'd0);
    tick();
    check("rewin_level", 32'(sif.level), 32'd1);
    check("rewin_prompt", 32'(sif.prompt != 3'd0), 32'd1);

    // Step 6: input_event during SHOW_ON is ignored, then reset mid-show
    sif.input_event = 1'b1;
    sif.input_code  = 2'(int'($urandom_range(0, 3)));
    repeat (2) tick();
    sif.input_event = 1'b0;
    check("show_ignores_input", 32'(sif.step_idx), 32'd0);
    check("show_still_on", 32'(sif.prompt != 3'd0), 32'd1);
    reset = 1'b0;
    tick();
    check("midgame_reset_outs", 32'(outs()), 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", 32'(outs()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
